// File: rtl/uart_pkg.sv
// Shared UART definitions. The receiver and the transmitter both use these
// values so that the two ends of a link stay in lockstep.
package uart_pkg;

    localparam int DATA_BITS              = 8;
    localparam int BIT_IDX_W              = $clog2(DATA_BITS);
    localparam int RATE_FREQ_BAUD_DEFAULT = 434;   // 50 MHz / 115200 bps
    localparam int FIFO_DEPTH_DEFAULT     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous write FIFO that sits between the peripheral bus and the
// transmitter. A push that arrives while full is accepted only when a pop
// frees a slot on the same edge; otherwise it is dropped without side effects.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_req,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             empty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             push_s;
    logic             pop_s;

    assign empty = (count_r == CNT_ZERO);
    assign full  = (count_r == CNT_FULL);
    assign rdata = mem_r[rd_ptr_r];

    // Qualify the requests and work out the next occupancy.
    always_comb begin
        pop_s        = pop_req & ~empty;
        push_s       = push_req & (~full | pop_s);
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW + 1)'(1);
            2'b01:   count_next_s = count_r - (AW + 1)'(1);
            default: count_next_s = count_r;
        endcase
        empty_next = (count_next_s == CNT_ZERO);
    end

    // Storage, pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first. Bytes are queued through a small FIFO and
// sent back to back with no idle gap; bit timing matches the receiver.
module uart_tx
    import uart_pkg::*;
#(
    parameter int RATE_FREQ_BAUD = RATE_FREQ_BAUD_DEFAULT,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_wr,
    output logic                 tx,
    output logic                 full,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(RATE_FREQ_BAUD);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(RATE_FREQ_BAUD - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t              state_r;
    tx_state_t              state_next_s;
    logic [CNT_W-1:0]       baud_cnt_r;
    logic [CNT_W-1:0]       baud_cnt_next_s;
    logic                   baud_expire_s;
    logic [BIT_IDX_W-1:0]   bit_idx_r;
    logic [BIT_IDX_W-1:0]   bit_idx_next_s;
    logic [DATA_BITS-1:0]   shift_r;
    logic [DATA_BITS-1:0]   shift_next_s;
    logic                   tx_r;
    logic                   tx_next_s;
    logic                   busy_r;
    logic                   busy_next_s;
    logic                   pop_s;
    logic [DATA_BITS-1:0]   fifo_head_s;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_next_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_req   (data_wr),
        .wdata      (data_in),
        .pop_req    (pop_s),
        .rdata      (fifo_head_s),
        .empty      (fifo_empty_s),
        .full       (fifo_full_s),
        .empty_next (fifo_empty_next_s)
    );

    assign baud_expire_s = (baud_cnt_r == CNT_LAST);
    assign tx            = tx_r;
    assign busy          = busy_r;
    assign full          = fifo_full_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; STOP chains straight into START when data waits.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_expire_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_expire_s && (bit_idx_r == BIT_LAST)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (!baud_expire_s) begin
                    state_next_s = ST_STOP;
                end else if (!fifo_empty_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: pop request, datapath next values and the next line level.
    always_comb begin
        pop_s           = 1'b0;
        baud_cnt_next_s = '0;
        bit_idx_next_s  = '0;
        shift_next_s    = shift_r;
        tx_next_s       = 1'b1;
        busy_next_s     = 1'b0;

        case (state_r)
            ST_IDLE: pop_s = ~fifo_empty_s;
            ST_STOP: pop_s = baud_expire_s & ~fifo_empty_s;
            default: pop_s = 1'b0;
        endcase

        // The counter is parked at zero in IDLE, so a pop always starts a full bit.
        if (state_r == ST_IDLE) begin
            baud_cnt_next_s = '0;
        end else if (baud_expire_s) begin
            baud_cnt_next_s = '0;
        end else begin
            baud_cnt_next_s = baud_cnt_r + CNT_W'(1);
        end

        if (state_r != ST_DATA) begin
            bit_idx_next_s = '0;
        end else if (baud_expire_s) begin
            bit_idx_next_s = bit_idx_r + BIT_IDX_W'(1);
        end else begin
            bit_idx_next_s = bit_idx_r;
        end

        if (pop_s) begin
            shift_next_s = fifo_head_s;
        end else if ((state_r == ST_DATA) && baud_expire_s) begin
            shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
        end else begin
            shift_next_s = shift_r;
        end

        // The line level is chosen from the next state so tx stays a flop output.
        case (state_next_s)
            ST_IDLE:  tx_next_s = 1'b1;
            ST_START: tx_next_s = 1'b0;
            ST_DATA:  tx_next_s = shift_next_s[0];
            ST_STOP:  tx_next_s = 1'b1;
            default:  tx_next_s = 1'b1;
        endcase

        busy_next_s = (state_next_s != ST_IDLE) | ~fifo_empty_next_s;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= '0;
            shift_r    <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            baud_cnt_r <= baud_cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            shift_r    <= shift_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= busy_next_s;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a behavioural 8N1 receiver on the line.
module tb_uart_tx;

    localparam int RATE  = 434;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * RATE;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_wr = 1'b0;
    logic       tx;
    logic       full;
    logic       busy;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    uart_tx #(
        .RATE_FREQ_BAUD (RATE),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .data_wr (data_wr),
        .tx      (tx),
        .full    (full),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: detect start, sample each bit near its middle.
    logic       rx_active = 1'b0;
    int         rx_phase  = 0;
    int         rx_bit    = 0;
    logic [7:0] rx_shift  = 8'h00;
    int         rx_bad    = 0;
    logic [7:0] rx_q [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active <= 1'b1;
                rx_phase  <= RATE / 2 + 1;
                rx_bit    <= 0;
            end
        end else if (rx_phase == RATE - 1) begin
            rx_phase <= 0;
            rx_bit   <= rx_bit + 1;
            if (rx_bit == 0) begin
                if (tx !== 1'b0) begin
                    rx_bad    <= rx_bad + 1;
                    rx_active <= 1'b0;
                end
            end else if (rx_bit <= 8) begin
                rx_shift <= {tx, rx_shift[7:1]};
            end else begin
                if (tx === 1'b1) rx_q.push_back(rx_shift);
                else rx_bad <= rx_bad + 1;
                rx_active <= 1'b0;
            end
        end else begin
            rx_phase <= rx_phase + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int limit, output int t_done);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(busy), 32'd0);
        t_done = cyc;
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        check_eq(tag, 32'(got), 32'(exp));
    endtask

    task automatic write_one(input logic [7:0] b);
        data_in = b;
        data_wr = 1'b1;
        tick(1);
        data_wr = 1'b0;
    endtask

    initial begin
        int         t0;
        int         t1;
        int         e1;
        int         tp;
        int         n_low;
        logic [9:0] frame;

        // Reset state.
        tick(3);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b1;
        tick(2);
        check_eq("idle_tx", 32'(tx), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single byte 0x55: exact bit boundaries and busy release.
        while (cyc < 9) tick(1);
        write_one(8'h55);
        check_eq("wr_busy", 32'(busy), 32'd1);
        check_eq("prepop_tx", 32'(tx), 32'd1);
        tick(1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("b%0d_first", k), 32'(tx), 32'(frame[k]));
            tick(RATE - 1);
            check_eq($sformatf("b%0d_last", k), 32'(tx), 32'(frame[k]));
            if (k == 9) check_eq("busy_before_end", 32'(busy), 32'd1);
            tick(1);
        end
        check_eq("end_tx", 32'(tx), 32'd1);
        check_eq("busy_drop", 32'(busy), 32'd0);
        check_rx("rx_55", 8'h55);

        // Loopback 0xA5.
        tick(5);
        write_one(8'hA5);
        wait_idle("idle_a5", 2 * FRAME, t1);
        check_rx("rx_a5", 8'hA5);

        // Back-to-back frames with no idle gap.
        tick(5);
        data_wr = 1'b1;
        data_in = 8'hA5; tick(1);
        data_in = 8'h3C; tick(1);
        check_eq("b2b_start", 32'(tx), 32'd0);
        t0 = cyc;
        data_in = 8'hFF; tick(1);
        data_in = 8'h00; tick(1);
        data_wr = 1'b0;
        wait_idle("idle_b2b", 5 * FRAME, t1);
        check_eq("b2b_len", 32'(t1 - t0), 32'(4 * FRAME));
        check_rx("b2b_0", 8'hA5);
        check_rx("b2b_1", 8'h3C);
        check_rx("b2b_2", 8'hFF);
        check_rx("b2b_3", 8'h00);

        // Overflow, then a push on the very edge the STOP expiry pops.
        tick(5);
        data_wr = 1'b1;
        data_in = 8'h01; tick(1);
        data_in = 8'h02; tick(1);
        e1 = cyc;
        check_eq("ovf_start", 32'(tx), 32'd0);
        check_eq("ovf_notfull", 32'(full), 32'd0);
        data_in = 8'h03; tick(1);
        data_in = 8'h04; tick(1);
        data_in = 8'h05; tick(1);
        check_eq("ovf_full", 32'(full), 32'd1);
        data_in = 8'h06; tick(1);
        check_eq("ovf_full_drop", 32'(full), 32'd1);
        data_wr = 1'b0;
        while (cyc < e1 + FRAME - 1) tick(1);
        check_eq("pp_stop_tx", 32'(tx), 32'd1);
        check_eq("pp_pre_full", 32'(full), 32'd1);
        write_one(8'h77);
        check_eq("pp_full", 32'(full), 32'd1);
        check_eq("pp_start", 32'(tx), 32'd0);
        wait_idle("idle_ovf", 7 * FRAME, t1);
        check_rx("ovf_01", 8'h01);
        check_rx("ovf_02", 8'h02);
        check_rx("ovf_03", 8'h03);
        check_rx("ovf_04", 8'h04);
        check_rx("ovf_05", 8'h05);
        check_rx("pp_77", 8'h77);
        check_eq("ovf_rx_len", 32'(rx_q.size()), 32'd0);

        // Reset in the middle of data bit 3 of 0xC3.
        tick(5);
        write_one(8'hC3);
        tick(1);
        tp = cyc;
        while (cyc < tp + 4 * RATE + 200) tick(1);
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_tx", 32'(tx), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_full", 32'(full), 32'd0);
        tick(3);
        @(negedge clk) rst = 1'b1;
        n_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) n_low++;
        end
        check_eq("post_rst_quiet", 32'(n_low), 32'd0);
        check_eq("post_rst_rx", 32'(rx_q.size()), 32'd0);
        write_one(8'h5A);
        wait_idle("idle_5a", 2 * FRAME, t1);
        check_rx("rx_5a", 8'h5A);
        check_eq("rx_framing", 32'(rx_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
